// File: rtl/mdu_arbiter_if.sv
// mdu_arbiter_if
//   Bundles every handshake and data signal of mdu_arbiter except clk/rst.
//   r0_* / r1_* : requester ports (request valid/ready, op, sign, a, b;
//                 result rvalid/rready, lo, hi, err)
//   core_*      : issue and result handshakes to the shared mul/div core
//   busy        : arbiter has an operation in flight
//   Modports: slave  = the arbiter
//             master = the environment (requesters and core)
interface mdu_arbiter_if;
  logic        r0_valid, r0_ready, r0_sign, r0_rvalid, r0_rready, r0_err;
  logic [1:0]  r0_op;
  logic [31:0] r0_a, r0_b, r0_lo, r0_hi;
  logic        r1_valid, r1_ready, r1_sign, r1_rvalid, r1_rready, r1_err;
  logic [1:0]  r1_op;
  logic [31:0] r1_a, r1_b, r1_lo, r1_hi;
  logic        core_valid, core_ready, core_sign, core_out_valid, core_out_ready;
  logic [1:0]  core_op;
  logic [31:0] core_a, core_b, core_lo, core_hi;
  logic        busy;

  modport slave (
    input  r0_valid, r0_op, r0_sign, r0_a, r0_b, r0_rready,
    output r0_ready, r0_rvalid, r0_lo, r0_hi, r0_err,
    input  r1_valid, r1_op, r1_sign, r1_a, r1_b, r1_rready,
    output r1_ready, r1_rvalid, r1_lo, r1_hi, r1_err,
    output core_valid, core_op, core_sign, core_a, core_b, core_out_ready,
    input  core_ready, core_out_valid, core_lo, core_hi,
    output busy
  );

  modport master (
    output r0_valid, r0_op, r0_sign, r0_a, r0_b, r0_rready,
    input  r0_ready, r0_rvalid, r0_lo, r0_hi, r0_err,
    output r1_valid, r1_op, r1_sign, r1_a, r1_b, r1_rready,
    input  r1_ready, r1_rvalid, r1_lo, r1_hi, r1_err,
    input  core_valid, core_op, core_sign, core_a, core_b, core_out_ready,
    output core_ready, core_out_valid, core_lo, core_hi,
    input  busy
  );
endinterface

// File: rtl/mdu_arbiter.sv
// mdu_arbiter
//   Shares one iterative multiply/divide core between two requesters
//   (port 0: pipeline MDU issue, port 1: auxiliary master). One operation in
//   flight; the result goes back to the port that issued it.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous, active-low reset
//   bus       : mdu_arbiter_if.slave (requester ports, core ports, busy)
//   dbg_state : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
// Handshakes: every valid/ready pair transfers on a rising edge where both are
//   high; the sender holds valid and its payload stable until that edge.
// Optional feature: define MDU_ARB_WDOG_EN to add a WAIT-state watchdog that
//   answers with err=1 after WDOG_CYCLES cycles without a core result.
module mdu_arbiter #(
  parameter int PRIO_FIXED  = 0,
  parameter int WDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  mdu_arbiter_if.slave bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t      state, state_nxt;
  logic        last_grant, owner, grant, accept, sel_legal, owner_rready;
  logic        core_done, wdog_fire;
  logic [1:0]  sel_op;
  logic [1:0]  op_q;
  logic        sign_q;
  logic [31:0] a_q, b_q;
  logic [31:0] lo_q [2];
  logic [31:0] hi_q [2];
  logic        err_q [2];

  // Arbitration and handshake decode
  always_comb begin
    if (bus.r0_valid && bus.r1_valid)
      grant = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant;
    else
      grant = ~bus.r0_valid;  // only port 1 can be asking (or nobody)
    // rst gating keeps ready low while reset is held
    accept       = rst && (state == IDLE) && (bus.r0_valid || bus.r1_valid);
    sel_op       = grant ? bus.r1_op : bus.r0_op;
    sel_legal    = (sel_op == 2'd1) || (sel_op == 2'd2);
    owner_rready = owner ? bus.r1_rready : bus.r0_rready;
    core_done    = (state == WAIT) && bus.core_out_valid;
  end

`ifdef MDU_ARB_WDOG_EN
  localparam int WDOG_W = 16;
  logic [WDOG_W-1:0] wdog_cnt;

  // Held at zero while issuing, so it starts from zero on WAIT entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                wdog_cnt <= '0;
    else if (state == ISSUE) wdog_cnt <= '0;
    else if (state == WAIT)  wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_fire = (state == WAIT) && !bus.core_out_valid &&
                     (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_fire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = sel_legal ? ISSUE : RESP;
      ISSUE: if (bus.core_ready) state_nxt = WAIT;
      WAIT:  if (core_done || wdog_fire) state_nxt = RESP;
      RESP:  if (owner_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.r0_ready       = accept && !grant;
    bus.r1_ready       = accept && grant;
    bus.core_valid     = (state == ISSUE);
    bus.core_out_ready = (state == WAIT);
    bus.r0_rvalid      = (state == RESP) && !owner;
    bus.r1_rvalid      = (state == RESP) && owner;
    bus.busy           = (state != IDLE);
    dbg_state          = state;
  end

  // Operand capture, ownership and per-port result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= 2'd0;
      sign_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        lo_q[i]  <= '0;
        hi_q[i]  <= '0;
        err_q[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        op_q       <= sel_op;
        sign_q     <= grant ? bus.r1_sign : bus.r0_sign;
        a_q        <= grant ? bus.r1_a : bus.r0_a;
        b_q        <= grant ? bus.r1_b : bus.r0_b;
        owner      <= grant;
        last_grant <= grant;
        // Illegal op answers directly; the core never sees it.
        if (!sel_legal) begin
          lo_q[grant]  <= '0;
          hi_q[grant]  <= '0;
          err_q[grant] <= 1'b1;
        end
      end
      if (core_done) begin
        lo_q[owner]  <= bus.core_lo;
        hi_q[owner]  <= bus.core_hi;
        err_q[owner] <= 1'b0;
      end else if (wdog_fire) begin
        lo_q[owner]  <= '0;
        hi_q[owner]  <= '0;
        err_q[owner] <= 1'b1;
      end
    end
  end

  assign bus.core_op   = op_q;
  assign bus.core_sign = sign_q;
  assign bus.core_a    = a_q;
  assign bus.core_b    = b_q;
  assign bus.r0_lo     = lo_q[0];
  assign bus.r0_hi     = hi_q[0];
  assign bus.r0_err    = err_q[0];
  assign bus.r1_lo     = lo_q[1];
  assign bus.r1_hi     = hi_q[1];
  assign bus.r1_err    = err_q[1];

endmodule

// File: tb/tb_mdu_arbiter.sv
// tb_mdu_arbiter
//   Randomized and directed stimulus for mdu_arbiter. A behavioural core model
//   computes results with plain arithmetic; expected responses per port and
//   expected core issues are kept in queues. Build with +define+MDU_ARB_WDOG_EN
//   to also exercise the watchdog (WDOG_CYCLES = 8 here).
module tb_mdu_arbiter;
  localparam int PRIO = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mdu_arbiter_if bus();

  mdu_arbiter #(.PRIO_FIXED(PRIO), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  bit          model_busy = 0, model_owner = 0, model_last = 1;
  logic [64:0] exp_q0[$], exp_q1[$];   // {err, hi, lo}
  logic [66:0] core_exp_q[$];          // {op, sign, a, b}
  int          acc_log[$];
  int          acc_cyc[2], rv_cyc[2];
  logic [64:0] last_res[2];
  bit          prev_rv[2], prev_hold[2];
  logic [64:0] prev_val[2];
  bit          rr_hold[2];
  int          core_lat = -1, stall_left = 0;
  bit          core_rdy_always = 0, core_hang = 0, core_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: 64-bit product of extended operands, or quotient/remainder
  function automatic logic [63:0] calc(logic [1:0] op, logic sg, logic [31:0] a, logic [31:0] b);
    logic [63:0] r;
    if (op == 2'd1) begin
      if (sg) r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else    r = {32'd0, a} * {32'd0, b};
    end else begin
      if (sg) r = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
      else    r = {a % b, a / b};
    end
    return r;
  endfunction

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(int p, logic [1:0] op, logic sg, logic [31:0] a, logic [31:0] b);
    int t = 0;
    bit acc = 0;
    if (p == 0) begin
      bus.r0_op = op; bus.r0_sign = sg; bus.r0_a = a; bus.r0_b = b; bus.r0_valid = 1'b1;
    end else begin
      bus.r1_op = op; bus.r1_sign = sg; bus.r1_a = a; bus.r1_b = b; bus.r1_valid = 1'b1;
    end
    while (!acc && t < 2000) begin
      @(negedge clk);
      t++;
      acc = (p == 0) ? (bus.r0_valid && bus.r0_ready) : (bus.r1_valid && bus.r1_ready);
    end
    if (!acc) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (p == 0) bus.r0_valid = 1'b0; else bus.r1_valid = 1'b0;
  endtask

  task automatic rand_req(int p);
    logic [1:0]  op;
    logic        sg;
    logic [31:0] a, b;
    int k;
    k  = $urandom_range(0, 7);
    op = (k == 0) ? (($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0) : ((k < 4) ? 2'd1 : 2'd2);
    sg = 1'($urandom_range(0, 1));
    a  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 100)) - 32'd50;
    b  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 100)) - 32'd50;
    if (op == 2'd2 && b == 32'd0) b = 32'd1;
    if (op == 2'd2 && sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
    tick($urandom_range(0, 3));
    send(p, op, sg, a, b);
  endtask

  task automatic drain();
    int t = 0;
    while ((model_busy || exp_q0.size() != 0 || exp_q1.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("drain_timeout", 0, 1);
    tick(1);
  endtask

  // Result consumers
  initial begin
    bus.r0_rready = 1'b0;
    bus.r1_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.r0_rready = rr_hold[0] ? 1'b0 : ($urandom_range(0, 3) != 0);
      bus.r1_rready = rr_hold[1] ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- core model ----------------
  initial begin : core_model
    bit          busy = 0, prev_stall = 0;
    int          cnt = 0;
    logic [63:0] res;
    logic [66:0] f, prev_f, e;
    bus.core_ready = 1'b0; bus.core_out_valid = 1'b0; bus.core_lo = '0; bus.core_hi = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 0; prev_stall = 0; stall_left = 0;
        bus.core_ready = 1'b0; bus.core_out_valid = 1'b0;
      end else begin
        f = {bus.core_op, bus.core_sign, bus.core_a, bus.core_b};
        if (prev_stall && bus.core_valid) check("core_fields_stable", f, prev_f);
        if (busy) begin
          bus.core_ready = 1'b0;
          if (cnt > 0) begin cnt--; bus.core_out_valid = 1'b0; end
          else begin bus.core_out_valid = 1'b1; {bus.core_hi, bus.core_lo} = res; end
          if (bus.core_out_valid && bus.core_out_ready) busy = 0;
        end else begin
          // stray result pulses only while the arbiter is not waiting
          if (!bus.core_out_ready && $urandom_range(0, 7) == 0) begin
            bus.core_out_valid = 1'b1; bus.core_lo = $urandom; bus.core_hi = $urandom;
          end else bus.core_out_valid = 1'b0;
          if (stall_left > 0) begin
            bus.core_ready = 1'b0;
            if (bus.core_valid) stall_left--;
          end else bus.core_ready = core_rdy_always || ($urandom_range(0, 3) != 0);
          if (bus.core_valid && bus.core_ready) begin
            if (core_exp_q.size() == 0) check("core_issue_unexpected", 1, 0);
            else begin e = core_exp_q.pop_front(); check("core_fields", f, e); end
            res  = calc(f[66:65], f[64], f[63:32], f[31:0]);
            cnt  = (core_lat < 0) ? $urandom_range(0, 4) : core_lat;
            busy = !core_hang;
          end
        end
        prev_stall = bus.core_valid && !bus.core_ready;
        prev_f     = f;
      end
    end
  end

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin : mon
    logic [64:0] val, e;
    logic [1:0]  op;
    bit          v0, v1, win, ex0, ex1, rv, rr, legal;
    if (!rst) begin
      exp_q0.delete(); exp_q1.delete(); core_exp_q.delete();
      model_busy = 0; model_last = 1;
      prev_rv[0] = 0; prev_rv[1] = 0; prev_hold[0] = 0; prev_hold[1] = 0;
    end else begin
      v0  = bus.r0_valid;
      v1  = bus.r1_valid;
      win = (v0 && v1) ? ((PRIO != 0) ? 1'b0 : ~model_last) : ~v0;
      ex0 = !model_busy && v0 && !win;
      ex1 = !model_busy && v1 && win;
      check("r0_ready", bus.r0_ready, ex0);
      check("r1_ready", bus.r1_ready, ex1);
      check("busy", bus.busy, model_busy);
      if (bus.core_valid) core_seen = 1;
      for (int p = 0; p < 2; p++) begin
        rv  = (p == 0) ? bus.r0_rvalid : bus.r1_rvalid;
        rr  = (p == 0) ? bus.r0_rready : bus.r1_rready;
        val = (p == 0) ? {bus.r0_err, bus.r0_hi, bus.r0_lo} : {bus.r1_err, bus.r1_hi, bus.r1_lo};
        if (rv) begin
          if (!(model_busy && model_owner == p[0])) check($sformatf("rvalid_unexpected_p%0d", p), rv, 0);
          if (!prev_rv[p]) rv_cyc[p] = cyc;
          if (prev_hold[p]) check($sformatf("resp_stable_p%0d", p), val, prev_val[p]);
          if (rr) begin
            if (p == 0 ? exp_q0.size() == 0 : exp_q1.size() == 0)
              check($sformatf("resp_extra_p%0d", p), 1, 0);
            else begin
              e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check($sformatf("resp_p%0d", p), val, e);
            end
            last_res[p] = val;
            model_busy  = 0;
          end
        end
        prev_hold[p] = rv && !rr;
        prev_val[p]  = val;
        prev_rv[p]   = rv;
      end
      if (ex0 || ex1) begin
        op    = win ? bus.r1_op : bus.r0_op;
        legal = (op == 2'd1) || (op == 2'd2);
        if (!legal || core_hang) e = {1'b1, 64'd0};
        else if (win) e = {1'b0, calc(op, bus.r1_sign, bus.r1_a, bus.r1_b)};
        else          e = {1'b0, calc(op, bus.r0_sign, bus.r0_a, bus.r0_b)};
        if (win) exp_q1.push_back(e); else exp_q0.push_back(e);
        if (legal)
          core_exp_q.push_back(win ? {op, bus.r1_sign, bus.r1_a, bus.r1_b}
                                   : {op, bus.r0_sign, bus.r0_a, bus.r0_b});
        model_busy   = 1;
        model_owner  = win;
        model_last   = win;
        acc_cyc[win] = cyc;
        acc_log.push_back(int'(win));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int t;
    rst = 1'b0;
    bus.r0_valid = 0; bus.r0_op = 0; bus.r0_sign = 0; bus.r0_a = 0; bus.r0_b = 0;
    bus.r1_valid = 0; bus.r1_op = 0; bus.r1_sign = 0; bus.r1_a = 0; bus.r1_b = 0;
    rr_hold[0] = 0; rr_hold[1] = 0;
    repeat (3) @(negedge clk);
    // reset state
    check("rst_r0_ready", bus.r0_ready, 0);
    check("rst_r1_rvalid", bus.r1_rvalid, 0);
    check("rst_r0_err", bus.r0_err, 0);
    check("rst_r0_lo", bus.r0_lo, 0);
    check("rst_core_valid", bus.core_valid, 0);
    check("rst_core_out_ready", bus.core_out_ready, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b1;
    tick(1);

    // both ports valid right after reset: 0 first, then 1, then 0 again
    core_rdy_always = 1; core_lat = 0;
    fork
      send(0, 2'd1, 1'b0, 32'd2, 32'd3);
      send(1, 2'd1, 1'b0, 32'd4, 32'd5);
    join
    drain();
    fork
      send(0, 2'd2, 1'b0, 32'd9, 32'd2);
      send(1, 2'd2, 1'b0, 32'd8, 32'd3);
    join
    drain();
    check("rr_count", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      check("rr_first", acc_log[0], 0);
      check("rr_second", acc_log[1], 1);
      check("rr_third", acc_log[2], 0);
    end

    // minimum latency: ready core, 1-cycle result
    send(1, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    check("min_latency", rv_cyc[1] - acc_cyc[1], 3);
    check("min_latency_res", last_res[1], {1'b0, 64'd1});

    // signed mul -3 * 5 with a 4-cycle core
    core_lat = 3;
    send(0, 2'd1, 1'b1, 32'hFFFF_FFFD, 32'd5);
    drain();
    check("mul_neg_res", last_res[0], {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});

    // divu 7/2 on port 1 with core_ready held low 3 cycles
    core_lat = 1; stall_left = 3;
    send(1, 2'd2, 1'b0, 32'd7, 32'd2);
    drain();
    check("divu_res", last_res[1], {1'b0, 32'd1, 32'd3});

    // illegal op: error one cycle after accept, core untouched
    core_seen = 0;
    send(0, 2'd3, 1'b0, 32'd1, 32'd1);
    drain();
    check("illegal_latency", rv_cyc[0] - acc_cyc[0], 1);
    check("illegal_res", last_res[0], {1'b1, 64'd0});
    check("illegal_no_core", core_seen, 0);

    // response held by requester for 5 cycles; port 1 must wait
    rr_hold[0] = 1;
    send(0, 2'd1, 1'b0, 32'd6, 32'd7);
    fork
      begin tick(1); send(1, 2'd1, 1'b0, 32'd9, 32'd9); end
      begin
        t = 0;
        while (!bus.r0_rvalid && t < 100) begin @(negedge clk); t++; end
        check("hold_rvalid_seen", bus.r0_rvalid, 1);
        repeat (5) begin
          @(negedge clk);
          check("hold_r1_ready", bus.r1_ready, 0);
          check("hold_r0_rvalid", bus.r0_rvalid, 1);
        end
        rr_hold[0] = 0;
      end
    join
    drain();
    check("hold_res_p1", last_res[1], {1'b0, 64'd81});

    // random traffic from both ports
    core_lat = -1; core_rdy_always = 0;
    fork
      for (int i = 0; i < 40; i++) rand_req(0);
      for (int i = 0; i < 40; i++) rand_req(1);
    join
    drain();

`ifdef MDU_ARB_WDOG_EN
    // core never answers: err after 8 WAIT cycles
    core_hang = 1; core_rdy_always = 1;
    send(0, 2'd1, 1'b0, 32'd5, 32'd6);
    begin
      int w;
      w = 0; t = 0;
      while (!bus.r0_rvalid && t < 200) begin
        @(negedge clk);
        t++;
        if (bus.core_out_ready) w++;
      end
      check("wdog_wait_cycles", w, 8);
    end
    drain();
    check("wdog_res", last_res[0], {1'b1, 64'd0});
    core_hang = 0;
`endif

    // reset during WAIT abandons the operation
    core_hang = 1; core_rdy_always = 1;
    send(0, 2'd1, 1'b1, 32'd11, 32'd13);
    t = 0;
    while (!bus.core_out_ready && t < 50) begin @(negedge clk); t++; end
    check("rst_wait_reached", bus.core_out_ready, 1);
    #2 rst = 1'b0;
    #1;
    check("wrst_busy", bus.busy, 0);
    check("wrst_core_out_ready", bus.core_out_ready, 0);
    check("wrst_core_a", bus.core_a, 0);
    check("wrst_core_op", bus.core_op, 0);
    check("wrst_r1_lo", bus.r1_lo, 0);
    check("wrst_r0_hi", bus.r0_hi, 0);
    check("wrst_r0_rvalid", bus.r0_rvalid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    core_hang = 0;
    tick(1);
    send(1, 2'd1, 1'b0, 32'd12, 32'd12);
    drain();
    check("post_rst_res", last_res[1], {1'b0, 64'd144});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
